// File: rtl/regfile_sb_if.sv
// Bundles the register file's pipeline-side signals: writeback, MEM/EX forwarding,
// load scoreboard control, ID read ports and their results.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2
) ();
  localparam int AW = $clog2(NREG);

  logic              wb_we_i;
  logic [AW-1:0]     wb_waddr_i;
  logic [XLEN-1:0]   wb_wdata_i;
  logic              wb_ld_i;
  logic              mem_we_i;
  logic [AW-1:0]     mem_waddr_i;
  logic [XLEN-1:0]   mem_wdata_i;
  logic              ex_we_i;
  logic [AW-1:0]     ex_waddr_i;
  logic [XLEN-1:0]   ex_alu_i;
  logic              ld_issue_i;
  logic [AW-1:0]     ld_rd_i;
  logic              flush_i;
  logic [NRP-1:0]    id_re_i;
  logic [NRP*AW-1:0] id_raddr_i;
  logic [NRP*XLEN-1:0] rdata_o;
  logic              stall_o;
  logic [NREG-1:0]   pending_o;

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i, wb_ld_i,
    output mem_we_i, mem_waddr_i, mem_wdata_i,
    output ex_we_i, ex_waddr_i, ex_alu_i,
    output ld_issue_i, ld_rd_i, flush_i,
    output id_re_i, id_raddr_i,
    input  rdata_o, stall_o, pending_o
  );

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i, wb_ld_i,
    input  mem_we_i, mem_waddr_i, mem_wdata_i,
    input  ex_we_i, ex_waddr_i, ex_alu_i,
    input  ld_issue_i, ld_rd_i, flush_i,
    input  id_re_i, id_raddr_i,
    output rdata_o, stall_o, pending_o
  );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with EX/MEM/WB forwarding and a pending-load scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward the writeback stage to same-cycle reads.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  logic            wb_wr;
  logic            wb_ld_clr;
  logic            ld_set;

  assign wb_wr     = bus.wb_we_i && (bus.wb_waddr_i != '0);
  assign wb_ld_clr = bus.wb_we_i && bus.wb_ld_i;
  assign ld_set    = bus.ld_issue_i && (bus.ld_rd_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_wr) begin
      regs_d[bus.wb_waddr_i] = bus.wb_wdata_i;
    end
  end

  // Set is applied last so a newer load wins over a same-cycle WB clear.
  always_comb begin
    pend_d = pend_q;
    if (bus.flush_i) begin
      pend_d = '0;
    end else if (wb_ld_clr) begin
      pend_d[bus.wb_waddr_i] = 1'b0;
    end
    if (ld_set) begin
      pend_d[bus.ld_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pend_q <= pend_d;
    end
  end

  logic [NRP-1:0]      port_stall;
  logic [NRP*XLEN-1:0] rdata_all;

  genvar p;
  generate
    for (p = 0; p < NRP; p++) begin : g_rp
      logic [AW-1:0]   ra;
      logic            re;
      logic            ex_hit;
      logic            mem_hit;
      logic            wb_hit;
      logic            pend_hit;
      logic            stall;
      logic [XLEN-1:0] data;

      assign ra      = bus.id_raddr_i[p*AW +: AW];
      assign re      = bus.id_re_i[p] && (ra != '0);
      assign ex_hit  = bus.ex_we_i  && (bus.ex_waddr_i  == ra);
      assign mem_hit = bus.mem_we_i && (bus.mem_waddr_i == ra);
      assign wb_hit  = bus.wb_we_i  && (bus.wb_waddr_i  == ra);
`ifdef REGFILE_WB_BYPASS_EN
      assign pend_hit = pend_q[ra] && !(wb_ld_clr && (bus.wb_waddr_i == ra));
`else
      assign pend_hit = pend_q[ra];
`endif

      always_comb begin
        data  = '0;
        stall = 1'b0;
        if (re) begin
          if (pend_hit) begin
            stall = 1'b1;
          end else if (ex_hit) begin
            data = bus.ex_alu_i;
          end else if (mem_hit) begin
            data = bus.mem_wdata_i;
          end else if (wb_hit) begin
`ifdef REGFILE_WB_BYPASS_EN
            data = bus.wb_wdata_i;
`else
            stall = 1'b1;
`endif
          end else begin
            data = regs_q[ra];
          end
        end
      end

      assign port_stall[p]              = stall;
      assign rdata_all[p*XLEN +: XLEN]  = data;
    end
  endgenerate

  // Forwarded EX/MEM values would otherwise leak through while reset is held.
  assign bus.rdata_o   = rst ? rdata_all : '0;
  assign bus.stall_o   = rst && (|port_stall);
  assign bus.pending_o = pend_q;

endmodule
